// File: rtl/sr_reg_bank.sv
// sr_reg_bank -- bank of WIDTH independent clocked set/reset channels.
//
// Each channel holds one bit of state q[i] that is updated on the rising
// clock edge only when en[i] is high. The s/r inputs behave like a classic
// SR latch. The BOTH_MODE parameter selects what s=r=1 means: hold, set
// wins, reset wins, or toggle. The block also provides registered
// rise/fall edge pulses and a sticky per-channel conflict flag for s=r=1.
//
// Optional feature: define SR_REG_BANK_CONFLICT_CNT_EN to add the
// conflict_cnt output. This is a saturating count of clock edges on which
// at least one enabled channel saw s=r=1. When the macro is undefined, the
// port and its counter do not exist.

module sr_reg_bank #(
  parameter int WIDTH     = 8,
  parameter int BOTH_MODE = 0,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             conflict_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] conflict
`ifdef SR_REG_BANK_CONFLICT_CNT_EN
  ,
  output logic [CNT_W-1:0] conflict_cnt
`endif
);

  // Encodings of the BOTH_MODE parameter.
  localparam int MODE_HOLD   = 0;
  localparam int MODE_SET    = 1;
  localparam int MODE_RESET  = 2;
  localparam int MODE_TOGGLE = 3;

  // Reject out-of-range configurations when the design is elaborated.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("sr_reg_bank: WIDTH must be 1..32");
  end
  if (BOTH_MODE < MODE_HOLD || BOTH_MODE > MODE_TOGGLE) begin : g_bad_mode
    $error("sr_reg_bank: BOTH_MODE must be 0..3");
  end
  if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
    $error("sr_reg_bank: CNT_W must be 2..16");
  end

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] conflict_hit;

  // Flag the channels that sample an enabled s=r=1 on this edge.
  assign conflict_hit = en & s & r;

  // Next-state decode: each channel resolves its own s/r pair.
  always_comb begin
    // NOTE: q_next gets a full default before the loop. Without it, a
    // channel with en=0 would leave q_next unassigned and infer a latch.
    q_next = q;
    for (int i = 0; i < WIDTH; i++) begin
      if (en[i]) begin
        unique case ({s[i], r[i]})
          2'b00: q_next[i] = q[i];
          2'b01: q_next[i] = 1'b0;
          2'b10: q_next[i] = 1'b1;
          2'b11: begin
            case (BOTH_MODE)
              MODE_SET:    q_next[i] = 1'b1;
              MODE_RESET:  q_next[i] = 1'b0;
              MODE_TOGGLE: q_next[i] = ~q[i];
              default:     q_next[i] = q[i];
            endcase
          end
          default: q_next[i] = q[i];
        endcase
      end
    end
  end

  // State, edge pulses and sticky conflict flags. Reset wins at once.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all registers here use non-blocking assignments. rise and fall
    // can then compare the old q with q_next on the same edge, with no
    // dependence on statement order.
    if (rst) begin
      q        <= '0;
      rise     <= '0;
      fall     <= '0;
      conflict <= '0;
    end else begin
      q        <= q_next;
      rise     <= q_next & ~q;
      fall     <= ~q_next & q;
      // A clear and a new conflict on the same edge leave the bit set.
      conflict <= (conflict_clr ? '0 : conflict) | conflict_hit;
    end
  end

  // The inverted output follows q directly, with no extra register stage.
  assign qb = ~q;

`ifdef SR_REG_BANK_CONFLICT_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating count of edges on which any channel saw a conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (conflict_clr) begin
      conflict_cnt <= (|conflict_hit) ? CNT_W'(1) : '0;
    end else if ((|conflict_hit) && (conflict_cnt != CNT_MAX)) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sr_reg_bank.sv
// tb_sr_reg_bank -- directed self-checking bench for sr_reg_bank.
//
// u_dut uses BOTH_MODE=0. u_m1, u_m2 and u_m3 use BOTH_MODE 1, 2 and 3 and
// share the same stimulus. When SR_REG_BANK_CONFLICT_CNT_EN is defined,
// u_sat (CNT_W=2) also exercises counter saturation.

`timescale 1ns/1ps

module tb_sr_reg_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] en, s, r;
  logic       conflict_clr;

  logic [7:0] q, qb, rise, fall, conflict;
  logic [7:0] q_m [1:3];
  logic [7:0] qb_m [1:3];
  logic [7:0] rise_m [1:3];
  logic [7:0] fall_m [1:3];
  logic [7:0] conflict_m [1:3];
`ifdef SR_REG_BANK_CONFLICT_CNT_EN
  logic [7:0] conflict_cnt;
  logic [7:0] cnt_m [1:3];
  logic [7:0] q_s, qb_s, rise_s, fall_s, conflict_s;
  logic [1:0] cnt_s;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sr_reg_bank #(.WIDTH(8), .BOTH_MODE(0), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .conflict_clr(conflict_clr),
    .q(q), .qb(qb), .rise(rise), .fall(fall), .conflict(conflict)
`ifdef SR_REG_BANK_CONFLICT_CNT_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  sr_reg_bank #(.WIDTH(8), .BOTH_MODE(1), .CNT_W(8)) u_m1 (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .conflict_clr(conflict_clr),
    .q(q_m[1]), .qb(qb_m[1]), .rise(rise_m[1]), .fall(fall_m[1]),
    .conflict(conflict_m[1])
`ifdef SR_REG_BANK_CONFLICT_CNT_EN
    , .conflict_cnt(cnt_m[1])
`endif
  );

  sr_reg_bank #(.WIDTH(8), .BOTH_MODE(2), .CNT_W(8)) u_m2 (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .conflict_clr(conflict_clr),
    .q(q_m[2]), .qb(qb_m[2]), .rise(rise_m[2]), .fall(fall_m[2]),
    .conflict(conflict_m[2])
`ifdef SR_REG_BANK_CONFLICT_CNT_EN
    , .conflict_cnt(cnt_m[2])
`endif
  );

  sr_reg_bank #(.WIDTH(8), .BOTH_MODE(3), .CNT_W(8)) u_m3 (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .conflict_clr(conflict_clr),
    .q(q_m[3]), .qb(qb_m[3]), .rise(rise_m[3]), .fall(fall_m[3]),
    .conflict(conflict_m[3])
`ifdef SR_REG_BANK_CONFLICT_CNT_EN
    , .conflict_cnt(cnt_m[3])
`endif
  );

`ifdef SR_REG_BANK_CONFLICT_CNT_EN
  sr_reg_bank #(.WIDTH(8), .BOTH_MODE(0), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .conflict_clr(conflict_clr),
    .q(q_s), .qb(qb_s), .rise(rise_s), .fall(fall_s), .conflict(conflict_s),
    .conflict_cnt(cnt_s)
  );
`endif

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one rising edge, then settle 1 ns past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] e, input logic [7:0] sv,
                       input logic [7:0] rv, input logic clr);
    en = e; s = sv; r = rv; conflict_clr = clr;
  endtask

  initial begin
    rst = 1'b1;
    drive(8'h00, 8'h00, 8'h00, 1'b0);

    // Reset state before any clock edge.
    #3;
    check("rst_q", q, 8'h00);
    check("rst_qb", qb, 8'hFF);
    check("rst_rise", rise, 8'h00);
    check("rst_conflict", conflict, 8'h00);
`ifdef SR_REG_BANK_CONFLICT_CNT_EN
    check("rst_cnt", conflict_cnt, 8'd0);
`endif
    tick();
    rst = 1'b0;
    tick();
    check("rel_rise", rise, 8'h00);
    check("rel_fall", fall, 8'h00);

    // Basic set, then reset, then hold.
    drive(8'hFF, 8'h0F, 8'h00, 1'b0);
    tick();
    check("set_q", q, 8'h0F);
    check("set_qb", qb, 8'hF0);
    check("set_rise", rise, 8'h0F);
    check("set_fall", fall, 8'h00);
    drive(8'hFF, 8'h00, 8'h03, 1'b0);
    tick();
    check("clr_q", q, 8'h0C);
    check("clr_fall", fall, 8'h03);
    check("clr_rise_1cyc", rise, 8'h00);
    drive(8'hFF, 8'h00, 8'h00, 1'b0);
    tick();
    check("hold_q", q, 8'h0C);
    check("hold_fall", fall, 8'h00);

    // A conflict on channel 1 holds q in mode 0 and sets the sticky flag.
    drive(8'hFF, 8'h02, 8'h02, 1'b0);
    tick();
    check("c1_q", q, 8'h0C);
    check("c1_conflict", conflict, 8'h02);
    // Load 0xA5 so that rise and fall pulses are pending.
    drive(8'hFF, 8'hA5, 8'h5A, 1'b0);
    tick();
    check("a5_q", q, 8'hA5);
    check("a5_rise", rise, 8'hA1);
    check("a5_fall", fall, 8'h08);
    check("a5_conflict_sticky", conflict, 8'h02);

    // Assert reset between edges, with busy inputs.
    rst = 1'b1;
    drive(8'hFF, 8'hFF, 8'h00, 1'b0);
    #2;
    check("async_q", q, 8'h00);
    check("async_qb", qb, 8'hFF);
    check("async_rise", rise, 8'h00);
    check("async_fall", fall, 8'h00);
    check("async_conflict", conflict, 8'h00);
    tick();
    tick();
    check("rst_ignore_q", q, 8'h00);
    rst = 1'b0;
    drive(8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    check("rel2_rise", rise, 8'h00);
    check("rel2_fall", fall, 8'h00);
    check("rel2_q", q, 8'h00);

    // Enable masking.
    drive(8'hF0, 8'hFF, 8'h00, 1'b0);
    tick();
    check("mask_q", q, 8'hF0);
    check("mask_conflict", conflict, 8'h00);
    drive(8'h0F, 8'hF0, 8'hF0, 1'b0);
    tick();
    check("mask_hold_q", q, 8'hF0);
    check("mask_no_conflict", conflict, 8'h00);

    // s=r=1 on channel 0 for three edges in each mode.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    drive(8'h01, 8'h01, 8'h01, 1'b0);
    tick();
    check("m0_q0_e1", q[0], 1'b0);
    check("m1_q0_e1", q_m[1][0], 1'b1);
    check("m2_q0_e1", q_m[2][0], 1'b0);
    check("m3_q0_e1", q_m[3][0], 1'b1);
    check("m3_rise_e1", rise_m[3][0], 1'b1);
    tick();
    check("m1_q0_e2", q_m[1][0], 1'b1);
    check("m3_q0_e2", q_m[3][0], 1'b0);
    check("m3_fall_e2", fall_m[3][0], 1'b1);
    tick();
    check("m0_q0_e3", q[0], 1'b0);
    check("m1_q0_e3", q_m[1][0], 1'b1);
    check("m2_q0_e3", q_m[2][0], 1'b0);
    check("m3_q0_e3", q_m[3][0], 1'b1);
    check("m0_conflict", conflict, 8'h01);
    check("m1_conflict", conflict_m[1], 8'h01);
    check("m2_conflict", conflict_m[2], 8'h01);
    check("m3_conflict", conflict_m[3], 8'h01);
`ifdef SR_REG_BANK_CONFLICT_CNT_EN
    check("cnt_after3", conflict_cnt, 8'd3);
`endif

    // A clear in the same cycle as a channel-2 conflict: the set wins.
    drive(8'h04, 8'h04, 8'h04, 1'b1);
    tick();
    check("clrset_conflict", conflict, 8'h04);
`ifdef SR_REG_BANK_CONFLICT_CNT_EN
    check("clrset_cnt", conflict_cnt, 8'd1);
`endif
    drive(8'h00, 8'h00, 8'h00, 1'b1);
    tick();
    check("clr_conflict", conflict, 8'h00);
`ifdef SR_REG_BANK_CONFLICT_CNT_EN
    check("clr_cnt", conflict_cnt, 8'd0);

    // Saturation with CNT_W=2: expected counts 1, 2, 3, 3, 3.
    drive(8'h01, 8'h01, 8'h01, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("sat_cnt_%0d", i), cnt_s, (i < 3) ? i : 3);
    end
    drive(8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    check("sat_hold", cnt_s, 2'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sr_reg_bank.md
SR_REG_BANK -- requirements
Module: sr_reg_bank

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, the number of independent SR channels (1..32).
REQ-002 The module SHALL have parameter BOTH_MODE, default 0, the s=r=1 resolution: 0 hold, 1 set wins, 2 reset wins, 3 toggle.
REQ-003 The module SHALL have parameter CNT_W, default 8, the conflict counter width (2..16).
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit, reset, asynchronous and active-high.
REQ-006 The module SHALL have port en, input, WIDTH bits, per-channel update enable.
REQ-007 The module SHALL have port s, input, WIDTH bits, per-channel set request.
REQ-008 The module SHALL have port r, input, WIDTH bits, per-channel reset request.
REQ-009 The module SHALL have port conflict_clr, input, 1 bit, clears sticky conflict flags and counter.
REQ-010 The module SHALL have port q, output, WIDTH bits, registered channel state.
REQ-011 The module SHALL have port qb, output, WIDTH bits, always the bitwise inverse of q.
REQ-012 The module SHALL have port rise, output, WIDTH bits, one-cycle pulse when q[i] goes 0->1.
REQ-013 The module SHALL have port fall, output, WIDTH bits, one-cycle pulse when q[i] goes 1->0.
REQ-014 The module SHALL have port conflict, output, WIDTH bits, sticky flag per channel that saw s=r=1 while enabled.
REQ-015 The module SHALL have port conflict_cnt, output, CNT_W bits, saturating conflict-cycle count (present only per REQ-030).

Function
REQ-016 For each channel i with en[i]=0, q[i] SHALL hold regardless of s[i] and r[i], and conflict[i] SHALL NOT be set.
REQ-017 For each channel i with en[i]=1, q[i] SHALL update at the next edge to: s,r = 00 hold; 01 -> 0; 10 -> 1; 11 -> per BOTH_MODE.
REQ-018 With BOTH_MODE=3, s=r=1 SHALL invert q[i] every enabled edge; q[i] SHALL never be X.
REQ-019 The latency from sampled s/r to q SHALL be one clock; qb SHALL be combinational from q, with zero extra latency.
REQ-020 rise[i]/fall[i] SHALL be registered: asserted for exactly the one cycle in which the new q[i] value first appears, deasserted otherwise; a hold produces no pulse.
REQ-021 conflict[i] SHALL set at the edge sampling en[i]=s[i]=r[i]=1, in every BOTH_MODE, and remain set until conflict_clr or rst.
REQ-022 conflict_clr=1 SHALL clear all conflict bits at the next edge; if a new conflict is sampled in the same cycle, that channel's bit SHALL read 1 (set beats clear).
REQ-023 Channels SHALL be fully independent; no channel's inputs affect another's q, rise, fall or conflict.

Reset
REQ-024 rst=1 SHALL immediately, without waiting for clk, force q=0, qb=all ones, rise=0, fall=0, conflict=0, conflict_cnt=0.
REQ-025 While rst=1, all inputs SHALL be ignored; the first edge after rst deasserts SHALL evaluate inputs normally.
REQ-026 Reset deassertion SHALL NOT generate rise or fall pulses.
REQ-027 Reset asserted mid-operation, including during a toggle or a pending pulse, SHALL abandon that update and apply REQ-024 values.

Configuration
REQ-028 The module SHALL use the macro SR_REG_BANK_CONFLICT_CNT_EN.
REQ-029 With SR_REG_BANK_CONFLICT_CNT_EN defined, conflict_cnt SHALL increment by 1 on each edge where at least one channel samples an enabled conflict.
  - Saturates at 2^CNT_W-1 with no wrap.
  - conflict_clr clears it to 0; clear plus a same-cycle conflict yields 1.
REQ-030 With SR_REG_BANK_CONFLICT_CNT_EN undefined, the conflict_cnt port and counter logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-031 The bench SHALL cover reset: rst=1 mid-run with q=8'hA5 -> q=8'h00, qb=8'hFF, conflict=0 with no clk edge; release -> no rise/fall.
REQ-032 The bench SHALL cover basic operation: en=8'hFF, s=8'h0F, r=8'h00 -> after one edge q=8'h0F, rise=8'h0F for one cycle; then s=0, r=8'h03 -> q=8'h0C, fall=8'h03.
REQ-033 The bench SHALL cover enable masking: en=8'hF0, s=8'hFF, r=0 from q=0 -> q=8'hF0 only; conflict stays 0.
REQ-034 The bench SHALL cover BOTH_MODE: en=1, s=r=1 on channel 0 for 3 edges from q=0, per mode 0/1/2/3 -> q0 = 0/1/0 then final 1 for toggle (1,0,1); conflict[0]=1.
REQ-035 The bench SHALL cover clear versus set: conflict_clr=1 in the same cycle channel 2 conflicts -> conflict=8'h04, conflict_cnt=1; next clr alone -> both 0.
REQ-036 The bench SHALL cover saturation (macro defined, CNT_W=2): 5 conflict cycles -> conflict_cnt=3, holding at 3.
